lif_stdp_layer: RTL and testbench

//  Parametrised successor to the two-neuron LIF/STDP core. N_IN input LIF neurons each feed one post LIF neuron

---
 rtl/lif_stdp_layer.sv | 204 ++++++++++++++++++++
 tb/tb_lif_stdp_layer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_stdp_layer.sv
`default_nettype none
// ============================================================================
//  Module      : lif_stdp_layer
//  Description : N_IN presynaptic leaky integrate-and-fire neurons, each
//                driving one postsynaptic LIF neuron through a plastic
//                synapse. Every synapse learns with pair-based STDP built on
//                saturating spike traces.
//  Ports       : clk, rst (async, active-high), en (global hold),
//                learn_en (weight updates), i_in (8-bit current per channel),
//                post_bias (extra post current) -> pre_spike, post_spike,
//                post_v (post membrane), weights (all synaptic weights)
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_stdp_layer #(
    parameter int N_IN       = 4,
    parameter int V_W        = 8,
    parameter int W_W        = 6,
    parameter int THRESH     = 128,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC     = 4,
    parameter int STDP_WIN   = 8,
    parameter int W_INIT     = 16,
    parameter int A_PLUS     = 1,
    parameter int A_MINUS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  learn_en,
    input  logic [N_IN*8-1:0]     i_in,
    input  logic [7:0]            post_bias,
    output logic [N_IN-1:0]       pre_spike,
    output logic                  post_spike,
    output logic [V_W-1:0]        post_v,
    output logic [N_IN*W_W-1:0]   weights
);

    // Integration width leaves headroom for v + bias + sum of all weights
    // before the result is clamped back to the membrane range.
    localparam int c_S_W = ((V_W > 10) ? V_W : 10) + 1;
    localparam int c_R_W = $clog2(REFRAC + 1);
    localparam int c_T_W = $clog2(STDP_WIN + 1);

    localparam logic [c_S_W-1:0] c_V_MAX    = {{(c_S_W-V_W){1'b0}}, {V_W{1'b1}}};
    localparam logic [c_S_W-1:0] c_THRESH   = c_S_W'(THRESH);
    localparam logic [c_R_W-1:0] c_REFRAC   = c_R_W'(REFRAC);
    localparam logic [c_T_W-1:0] c_STDP_WIN = c_T_W'(STDP_WIN);
    localparam logic [W_W-1:0]   c_W_INIT   = W_W'(W_INIT);
    localparam logic [W_W-1:0]   c_W_MAX    = {W_W{1'b1}};
    localparam logic [W_W-1:0]   c_A_PLUS   = W_W'(A_PLUS);
    localparam logic [W_W-1:0]   c_A_MINUS  = W_W'(A_MINUS);

    // Leak, add input current, clamp at the top of the membrane range.
    function automatic logic [c_S_W-1:0] f_integrate(input logic [V_W-1:0]   v,
                                                     input logic [c_S_W-1:0] cur);
        logic [c_S_W-1:0] s;
        s = c_S_W'(v) - c_S_W'(v >> LEAK_SHIFT) + cur;
        if (s > c_V_MAX) begin
            s = c_V_MAX;
        end
        return s;
    endfunction

    logic [N_IN-1:0]  pre_spike_all;
    logic [V_W-1:0]   post_v_q,     post_v_d;
    logic [c_R_W-1:0] post_ref_q,   post_ref_d;
    logic             post_spike_q, post_spike_d;
    logic [c_T_W-1:0] post_trace_q, post_trace_d;
    logic [c_S_W-1:0] w_post_i;
    logic [c_S_W-1:0] w_post_s;

    // ------------------------------------------------------------------------
    // Presynaptic neuron, trace and synapse per channel
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N_IN; k++) begin : g_ch
        logic [V_W-1:0]   v_q,     v_d;
        logic [c_R_W-1:0] ref_q,   ref_d;
        logic             spike_q, spike_d;
        logic [c_T_W-1:0] trace_q, trace_d;
        logic [W_W-1:0]   w_q,     w_d;
        logic [c_S_W-1:0] w_s;

        assign w_s = f_integrate(v_q, c_S_W'(i_in[8*k +: 8]));

        always_comb begin
            v_d     = v_q;
            ref_d   = ref_q;
            spike_d = spike_q;
            trace_d = trace_q;
            w_d     = w_q;
            if (en) begin
                if (ref_q != '0) begin
                    v_d     = '0;
                    ref_d   = ref_q - 1'b1;
                    spike_d = 1'b0;
                end else if (w_s >= c_THRESH) begin
                    v_d     = '0;
                    ref_d   = c_REFRAC;
                    spike_d = 1'b1;
                end else begin
                    v_d     = w_s[V_W-1:0];
                    spike_d = 1'b0;
                end

                if (spike_d) begin
                    trace_d = c_STDP_WIN;
                end else if (trace_q != '0) begin
                    trace_d = trace_q - 1'b1;
                end

                // Traces are sampled before this edge; coincident pre and
                // post spikes fall through both branches and leave w alone.
                if (learn_en) begin
                    if (post_spike_d && !spike_d && (trace_q != '0)) begin
                        w_d = (w_q > c_W_MAX - c_A_PLUS) ? c_W_MAX : w_q + c_A_PLUS;
                    end else if (spike_d && !post_spike_d && (post_trace_q != '0)) begin
                        w_d = (w_q < c_A_MINUS) ? '0 : w_q - c_A_MINUS;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q     <= '0;
                ref_q   <= '0;
                spike_q <= 1'b0;
                trace_q <= '0;
                w_q     <= c_W_INIT;
            end else begin
                v_q     <= v_d;
                ref_q   <= ref_d;
                spike_q <= spike_d;
                trace_q <= trace_d;
                w_q     <= w_d;
            end
        end

        assign pre_spike_all[k]       = spike_q;
        assign weights[W_W*k +: W_W]  = w_q;
    end

    // ------------------------------------------------------------------------
    // Postsynaptic neuron: integrates the weights of last cycle's pre spikes
    // ------------------------------------------------------------------------
    always_comb begin
        w_post_i = c_S_W'(post_bias);
        for (int k = 0; k < N_IN; k++) begin
            if (pre_spike_all[k]) begin
                w_post_i = w_post_i + c_S_W'(weights[W_W*k +: W_W]);
            end
        end
    end

    assign w_post_s = f_integrate(post_v_q, w_post_i);

    always_comb begin
        post_v_d     = post_v_q;
        post_ref_d   = post_ref_q;
        post_spike_d = post_spike_q;
        post_trace_d = post_trace_q;
        if (en) begin
            if (post_ref_q != '0) begin
                post_v_d     = '0;
                post_ref_d   = post_ref_q - 1'b1;
                post_spike_d = 1'b0;
            end else if (w_post_s >= c_THRESH) begin
                post_v_d     = '0;
                post_ref_d   = c_REFRAC;
                post_spike_d = 1'b1;
            end else begin
                post_v_d     = w_post_s[V_W-1:0];
                post_spike_d = 1'b0;
            end

            if (post_spike_d) begin
                post_trace_d = c_STDP_WIN;
            end else if (post_trace_q != '0) begin
                post_trace_d = post_trace_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_v_q     <= '0;
            post_ref_q   <= '0;
            post_spike_q <= 1'b0;
            post_trace_q <= '0;
        end else begin
            post_v_q     <= post_v_d;
            post_ref_q   <= post_ref_d;
            post_spike_q <= post_spike_d;
            post_trace_q <= post_trace_d;
        end
    end

    // Held spike registers must not look like fresh pulses while disabled.
    assign pre_spike  = pre_spike_all & {N_IN{en}};
    assign post_spike = post_spike_q & en;
    assign post_v     = post_v_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_stdp_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_stdp_layer
//  Description : Directed self-checking bench for lif_stdp_layer with
//                hand-computed expected spikes, membrane values and weights.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_stdp_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        learn_en;
    logic [31:0] i_in;
    logic [7:0]  post_bias;
    logic [3:0]  pre_spike;
    logic        post_spike;
    logic [7:0]  post_v;
    logic [23:0] weights;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_stdp_layer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .learn_en   (learn_en),
        .i_in       (i_in),
        .post_bias  (post_bias),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .post_v     (post_v),
        .weights    (weights)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pack_w(input int w3, input int w2, input int w1, input int w0);
        return {w3[5:0], w2[5:0], w1[5:0], w0[5:0]};
    endfunction

    // One active edge; returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // A current of 200 fires a resting pre neuron on a single edge.
    task automatic pre_pulse(input int k);
        i_in = '0;
        i_in[8*k +: 8] = 8'd200;
        tick();
        i_in = '0;
    endtask

    task automatic ltp_pair(input int k);
        pre_pulse(k);
        tick();
        post_bias = 8'd128;
        tick();
        post_bias = 8'd0;
        idle(12);
    endtask

    task automatic ltd_pair(input int k);
        post_bias = 8'd128;
        tick();
        post_bias = 8'd0;
        idle(2);
        pre_pulse(k);
        idle(12);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        learn_en  = 1'b1;
        i_in      = '0;
        post_bias = 8'd0;
        idle(2);
        check("rst_pre",     pre_spike,  0);
        check("rst_post",    post_spike, 0);
        check("rst_post_v",  post_v,     0);
        check("rst_weights", weights,    pack_w(16, 16, 16, 16));
        rst = 1'b0;

        // Constant I=32 on ch0: spikes on edges 5, 14, 23.
        i_in[7:0] = 8'd32;
        for (int e = 1; e <= 23; e++) begin
            tick();
            check("t2_pre", pre_spike, (e == 5 || e == 14 || e == 23) ? 1 : 0);
            check("t2_post_spike", post_spike, 0);
            if (e == 6)  check("t2_post_v6",  post_v, 16);
            if (e == 15) check("t2_post_v15", post_v, 31);
            if (e == 23) check("t2_post_v23", post_v, 23);
        end

        // Asynchronous reset while pre_spike is high.
        #2 rst = 1'b1;
        #1;
        check("t1_pre",     pre_spike,  0);
        check("t1_post",    post_spike, 0);
        check("t1_post_v",  post_v,     0);
        check("t1_weights", weights,    pack_w(16, 16, 16, 16));
        @(negedge clk);
        rst  = 1'b0;
        i_in = '0;

        // LTP: pre0 at t, post at t+2.
        pre_pulse(0);
        check("t3_pre", pre_spike, 1);
        tick();
        check("t3_post_v", post_v, 16);
        post_bias = 8'd128;
        tick();
        check("t3_post_spike", post_spike, 1);
        check("t3_weights", weights, pack_w(16, 16, 16, 17));
        post_bias = 8'd0;
        idle(12);

        // LTD: post first, pre1 three edges later.
        post_bias = 8'd128;
        tick();
        check("t4_post_spike", post_spike, 1);
        post_bias = 8'd0;
        idle(2);
        pre_pulse(1);
        check("t4_pre", pre_spike, 2);
        check("t4_weights", weights, pack_w(16, 16, 15, 17));
        tick();
        check("t4_refrac_post_v", post_v, 0);
        idle(11);

        // Saturation at both ends.
        repeat (60) ltp_pair(0);
        check("t5_ltp_sat", weights, pack_w(16, 16, 15, 63));
        repeat (20) ltd_pair(2);
        check("t5_ltd_sat", weights, pack_w(16, 0, 15, 63));

        learn_en = 1'b0;
        repeat (2) ltp_pair(1);
        repeat (2) ltd_pair(0);
        check("t5_frozen", weights, pack_w(16, 0, 15, 63));
        learn_en = 1'b1;

        // Coincident pre1/post spikes, second time with both traces live.
        i_in[15:8] = 8'd200;
        post_bias  = 8'd128;
        tick();
        check("t6_pre_a",  pre_spike,  2);
        check("t6_post_a", post_spike, 1);
        i_in      = '0;
        post_bias = 8'd0;
        idle(4);
        i_in[15:8] = 8'd200;
        post_bias  = 8'd128;
        tick();
        check("t6_pre_b",   pre_spike,  2);
        check("t6_post_b",  post_spike, 1);
        check("t6_same_w",  weights,    pack_w(16, 0, 15, 63));
        i_in      = '0;
        post_bias = 8'd0;
        idle(12);

        // Build up state, then hold it with en=0.
        pre_pulse(1);
        i_in[7:0] = 8'd32;
        repeat (5) tick();
        check("t6_pre0_spike", pre_spike, 1);
        check("t6_post_v15",   post_v,    15);
        en = 1'b0;
        #1;
        check("t6_en0_mask", pre_spike, 0);
        for (int e = 0; e < 10; e++) begin
            tick();
            check("t6_hold_pre",    pre_spike,  0);
            check("t6_hold_post",   post_spike, 0);
            check("t6_hold_post_v", post_v,     15);
        end
        check("t6_hold_w", weights, pack_w(16, 0, 15, 63));
        en = 1'b1;
        #1;
        check("t6_resume_pre", pre_spike, 1);
        tick();
        check("t6_resume_post_v", post_v, 78);
        check("t6_resume_pre1",   pre_spike, 0);
        for (int e = 2; e <= 9; e++) begin
            tick();
            check("t6_resume_period", pre_spike, (e == 9) ? 1 : 0);
        end

        // Reset restores the initial weights.
        #2 rst = 1'b1;
        #1;
        check("end_rst_w",      weights, pack_w(16, 16, 16, 16));
        check("end_rst_post_v", post_v,  0);
        check("end_rst_pre",    pre_spike, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
